nano_mem_arbiter: RTL
=====================

Name: nano_mem_arbiter

Overview:
- Shares the single-port program/data RAM of the Nano CPU system between two requesters: the CPU core and the serial program loader/debug port.
- Sits between both requesters and the RAM macro inside tt_um_galaguna_NanoSys_fit.
- Provides per-requester req/gnt/rvalid handshakes, round-robin arbitration, and a loader lock that freezes the CPU out for program download.

Parameters:
- AW, 7, RAM address width in bits (128 words).
- DW, 4, RAM data width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  CPU access request; held with command until granted.
- cpu_we  in  1  CPU write enable (1=write, 0=read).
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU command accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid on cpu_rdata.
- cpu_rdata  out  DW  CPU read data.
- ldr_req  in  1  loader access request.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_lock  in  1  loader requests exclusive ownership.
- ldr_gnt  out  1  loader command accepted this cycle.
- ldr_rvalid  out  1  loader read data valid.
- ldr_rdata  out  DW  loader read data.
- lock_ack  out  1  exclusive ownership held by loader.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; valid one cycle after a read with mem_en=1.

Behaviour:
- Reset values: all gnt/rvalid/lock_ack/mem_en/mem_we = 0; rdata, mem_addr, mem_wdata = 0; priority pointer = CPU; state = OPEN.
- Grants are combinational from current req and registered state; at most one gnt per cycle.
- The mem_* bus is driven from the granted requester. With no grant: mem_en=0, mem_we=0, addr/wdata hold 0.
- Handshake: a command completes on the cycle its gnt=1. The requester may change or drop req the next cycle. An ungranted req must stay stable; the arbiter does not latch commands.
- Read latency: exactly 1 cycle.
  - A granted read at cycle N produces <who>_rvalid=1 at N+1, with <who>_rdata = mem_rdata (passed through).
  - rdata of the non-owner stays at its last value; rvalid is a 1-cycle pulse.
- Writes produce no rvalid.
- Round-robin, state OPEN:
  - Only one req: grant it.
  - Both req: grant the requester the pointer names; the pointer then flips to the other requester.
  - The pointer updates only on a contested grant.
- Lock FSM, states OPEN, DRAIN, LOCKED:
  - OPEN -> DRAIN when ldr_lock=1. In DRAIN, cpu_gnt is forced 0 and ldr may still be granted.
  - DRAIN -> LOCKED the next cycle; one cycle covers any CPU read issued the previous cycle.
  - LOCKED: lock_ack=1 (registered); only the loader is granted.
  - LOCKED -> OPEN when ldr_lock=0; lock_ack falls the same edge, pointer = CPU.
  - ldr_lock dropped in DRAIN -> OPEN directly, lock_ack never asserted.
- cpu_req held while locked: no grant, no error; the CPU stalls.
- Simultaneous ldr_lock rise and contested req: the lock wins that cycle; the loader is granted if requesting, the CPU is not.
- Reset mid-access: an outstanding rvalid is dropped; the lock is released.
- Address and data pass through unmodified. No wrap logic; the RAM sees the full AW bits.

Optional Feature:
- Macro: NANO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority replaces round-robin; the loader always wins a contested cycle. The pointer register is removed. The lock FSM is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset -> all outputs 0, mem_en=0; release rst, no reqs -> mem_en stays 0.
- CPU write addr 0x05 data 0xA, then read 0x05 -> cpu_gnt both cycles; cpu_rvalid=1 with cpu_rdata=0xA one cycle after the read grant; ldr_rvalid stays 0.
- Both req continuously for 4 cycles -> grants alternate CPU, LDR, CPU, LDR; with NANO_ARB_FIXED_PRIO_EN -> LDR all 4 cycles.
- Assert ldr_lock while cpu_req=1 -> cycle 1 DRAIN (cpu_gnt=0), lock_ack=1 from cycle 2. Loader writes 0x00..0x03 succeed, cpu_gnt stays 0. Drop lock -> lock_ack=0 next edge; CPU granted next cycle.
- Pulse ldr_lock for 1 cycle -> lock_ack never 1; the CPU resumes after one lost cycle.
- Assert rst one cycle after a CPU read grant -> cpu_rvalid=0; FSM returns to OPEN.

Source files
------------

// File: rtl/nano_mem_arbiter.sv
// nano_mem_arbiter: shares the single-port Nano RAM between the CPU and the loader,
// with round-robin arbitration and a loader lock. Define NANO_ARB_FIXED_PRIO_EN for fixed loader priority.
`timescale 1ns/1ps
module nano_mem_arbiter #(
  parameter int AW = 7,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic          lock_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {OPEN, DRAIN, LOCKED} state_t;

  state_t        state;
  logic          contested;
  logic [DW-1:0] cpu_rdata_hold;
  logic [DW-1:0] ldr_rdata_hold;

  assign contested = cpu_req & ldr_req;

`ifndef NANO_ARB_FIXED_PRIO_EN
  // ptr_ldr=1 means the loader wins the next contested cycle
  logic ptr_ldr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_ldr <= 1'b0;
    end else if (state == OPEN && contested) begin
      ptr_ldr <= cpu_gnt;
    end else if (state == LOCKED && !ldr_lock) begin
      ptr_ldr <= 1'b0;
    end
  end
`endif

  // Grants are combinational; a rising lock beats the pointer on a contested cycle
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (!rst) begin
      if (state == OPEN) begin
        if (contested) begin
`ifdef NANO_ARB_FIXED_PRIO_EN
          ldr_gnt = 1'b1;
`else
          if (ldr_lock || ptr_ldr) begin
            ldr_gnt = 1'b1;
          end else begin
            cpu_gnt = 1'b1;
          end
`endif
        end else begin
          cpu_gnt = cpu_req;
          ldr_gnt = ldr_req;
        end
      end else begin
        ldr_gnt = ldr_req;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | ldr_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Read data passes straight through on the rvalid cycle, then is held for the owner
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_hold;
  assign ldr_rdata = ldr_rvalid ? mem_rdata : ldr_rdata_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= OPEN;
      lock_ack       <= 1'b0;
      cpu_rvalid     <= 1'b0;
      ldr_rvalid     <= 1'b0;
      cpu_rdata_hold <= '0;
      ldr_rdata_hold <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ldr_rvalid <= ldr_gnt & ~ldr_we;
      if (cpu_rvalid) cpu_rdata_hold <= mem_rdata;
      if (ldr_rvalid) ldr_rdata_hold <= mem_rdata;
      case (state)
        OPEN: begin
          if (ldr_lock) state <= DRAIN;
        end
        DRAIN: begin
          // one blocked cycle lets any CPU read issued just before the lock complete
          if (ldr_lock) begin
            state    <= LOCKED;
            lock_ack <= 1'b1;
          end else begin
            state <= OPEN;
          end
        end
        LOCKED: begin
          if (!ldr_lock) begin
            state    <= OPEN;
            lock_ack <= 1'b0;
          end
        end
        default: begin
          state    <= OPEN;
          lock_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
